multicycle_control_fsm: RTL and testbench

//  Multicycle successor to the single-cycle control unit: sequences each instruction through

---
 rtl/multicycle_control_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer
// with cache-wait timeout, sticky halt/error and illegal-op pulse.
package cpu_types_pkg;
  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2a,
    SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module multicycle_control_fsm #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_func,
  input  logic       equal,
  output logic       imemREN,
  output logic       dmemREN,
  output logic       dmemWEN,
  output logic       ir_wen,
  output logic       pc_wen,
  output logic [1:0] pc_src,
  output logic       reg_wen,
  output logic [1:0] reg_dst,
  output logic [1:0] wsel,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic       ext_op,
  output logic       upper_imm,
  output logic       reg_zero,
  output logic       halt,
  output logic       bus_err,
  output logic       illegal,
  output logic [2:0] state
);
  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    K_ALU_R, K_ALU_I, K_LW, K_SW,
    K_BEQ, K_BNE, K_J, K_JAL, K_JR,
    K_HALT, K_NOP
  } kind_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  kind_t            kind;
  aluop_t           d_alu;
  logic             d_src;
  logic             d_ext;
  logic             d_up;
  logic             d_rz;

  assign timeout = (WAIT_MAX > 0) && (cnt_q == LAST);
  assign state   = RST ? 3'd0 : state_q;

  // Classify the latched IR and pick its ALU controls.
  always_comb begin
    kind  = K_NOP;
    d_alu = ALU_SLL;
    d_src = 1'b0;
    d_ext = 1'b1;
    d_up  = 1'b0;
    d_rz  = 1'b0;
    unique case (instr_op)
      RTYPE: begin
        kind = K_ALU_R;
        unique case (instr_func)
          SLL:     d_alu = ALU_SLL;
          SRL:     d_alu = ALU_SRL;
          ADD:     d_alu = ALU_ADD;
          ADDU:    d_alu = ALU_ADD;
          SUB:     d_alu = ALU_SUB;
          SUBU:    d_alu = ALU_SUB;
          AND:     d_alu = ALU_AND;
          OR:      d_alu = ALU_OR;
          XOR:     d_alu = ALU_XOR;
          NOR:     d_alu = ALU_NOR;
          SLT:     d_alu = ALU_SLT;
          SLTU:    d_alu = ALU_SLTU;
          JR:      kind  = K_JR;
          default: kind  = K_NOP;
        endcase
      end
      ADDIU: begin
        kind  = K_ALU_I;
        d_alu = ALU_ADD;
        d_src = 1'b1;
      end
      SLTI: begin
        kind  = K_ALU_I;
        d_alu = ALU_SLT;
        d_src = 1'b1;
      end
      SLTIU: begin
        kind  = K_ALU_I;
        d_alu = ALU_SLTU;
        d_src = 1'b1;
      end
      ANDI: begin
        kind  = K_ALU_I;
        d_alu = ALU_AND;
        d_src = 1'b1;
        d_ext = 1'b0;
      end
      ORI: begin
        kind  = K_ALU_I;
        d_alu = ALU_OR;
        d_src = 1'b1;
        d_ext = 1'b0;
      end
      XORI: begin
        kind  = K_ALU_I;
        d_alu = ALU_XOR;
        d_src = 1'b1;
        d_ext = 1'b0;
      end
      LUI: begin
        kind  = K_ALU_I;
        d_alu = ALU_OR;
        d_src = 1'b1;
        d_ext = 1'b0;
        d_up  = 1'b1;
        d_rz  = 1'b1;
      end
      LW: begin
        kind  = K_LW;
        d_alu = ALU_ADD;
        d_src = 1'b1;
      end
      SW: begin
        kind  = K_SW;
        d_alu = ALU_ADD;
        d_src = 1'b1;
      end
      BEQ: begin
        kind  = K_BEQ;
        d_alu = ALU_SUB;
      end
      BNE: begin
        kind  = K_BNE;
        d_alu = ALU_SUB;
      end
      J:       kind = K_J;
      JAL:     kind = K_JAL;
      HALT:    kind = K_HALT;
      default: kind = K_NOP;
    endcase
  end

  // Sequence states; the wait counter restarts on every transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (ihit) begin
            state_q <= S_DECODE;
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q <= S_ERROR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= (kind == K_HALT) ? S_HALTED
                                      : S_EXEC;
        end
        S_EXEC: begin
          unique case (kind)
            K_LW, K_SW:       state_q <= S_MEM;
            K_ALU_R, K_ALU_I: state_q <= S_WB;
            default:          state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dhit) begin
            state_q <= (kind == K_LW) ? S_WB
                                      : S_FETCH;
            cnt_q   <= '0;
          end else if (timeout) begin
            state_q <= S_ERROR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB:     state_q <= S_FETCH;
        S_HALTED: state_q <= S_HALTED;
        S_ERROR:  state_q <= S_ERROR;
        default: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Datapath controls; ALU controls stay up through MEM/WB so
  // the address and result remain stable while waiting.
  always_comb begin
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    pc_src    = 2'd0;
    reg_wen   = 1'b0;
    reg_dst   = 2'd0;
    wsel      = 2'd0;
    alu_op    = ALU_SLL;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    upper_imm = 1'b0;
    reg_zero  = 1'b0;
    halt      = 1'b0;
    bus_err   = 1'b0;
    illegal   = 1'b0;
    if (!RST) begin
      ext_op = 1'b1;
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
        alu_op    = d_alu;
        alu_src   = d_src;
        ext_op    = d_ext;
        upper_imm = d_up;
        reg_zero  = d_rz;
      end
      unique case (state_q)
        S_FETCH: begin
          imemREN = 1'b1;
          ir_wen  = ihit;
        end
        S_DECODE: illegal = (kind == K_NOP);
        S_EXEC: begin
          unique case (kind)
            K_BEQ: begin
              pc_wen = 1'b1;
              pc_src = equal ? 2'd1 : 2'd0;
            end
            K_BNE: begin
              pc_wen = 1'b1;
              pc_src = equal ? 2'd0 : 2'd1;
            end
            K_J: begin
              pc_wen = 1'b1;
              pc_src = 2'd2;
            end
            K_JAL: begin
              pc_wen  = 1'b1;
              pc_src  = 2'd2;
              reg_wen = 1'b1;
              reg_dst = 2'd2;
              wsel    = 2'd2;
            end
            K_JR: begin
              pc_wen = 1'b1;
              pc_src = 2'd3;
            end
            K_NOP:   pc_wen = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          dmemREN = (kind == K_LW);
          dmemWEN = (kind == K_SW);
          pc_wen  = dhit && (kind == K_SW);
        end
        S_WB: begin
          reg_wen = 1'b1;
          pc_wen  = 1'b1;
          reg_dst = (kind == K_ALU_R) ? 2'd1 : 2'd0;
          wsel    = (kind == K_LW) ? 2'd1 : 2'd0;
        end
        S_HALTED: halt    = 1'b1;
        S_ERROR:  bus_err = 1'b1;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table, hand and random checks
// against a cycle-trace model built from instruction classes.
module tb_multicycle_control_fsm;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       imem, dren, dwen, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd, ws;
    logic [3:0] aop;
    logic       asrc, ext, up, rz, halt, berr, ill;
  } obs_t;

  typedef enum int {
    K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_JR, K_BAD, K_HALT
  } kind_t;

  typedef struct {
    logic [5:0] op, fn;
    kind_t      k;
    logic [3:0] aop;
    logic [3:0] f;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ihit = 1'b0, dhit = 1'b0, equal = 1'b0;
  logic [5:0] instr_op = 6'd0, instr_func = 6'd0;
  wire obs_t  o4, o0;
  int         n_chk = 0, n_fail = 0;
  vec_t       tab[$];
  vec_t       v;
  obs_t       e;

  always #5 CLK = ~CLK;

  multicycle_control_fsm #(.WAIT_MAX(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .instr_op(instr_op), .instr_func(instr_func),
    .equal(equal),
    .imemREN(o4.imem), .dmemREN(o4.dren),
    .dmemWEN(o4.dwen), .ir_wen(o4.irw),
    .pc_wen(o4.pcw), .pc_src(o4.pcs),
    .reg_wen(o4.rw), .reg_dst(o4.rd), .wsel(o4.ws),
    .alu_op(o4.aop), .alu_src(o4.asrc),
    .ext_op(o4.ext), .upper_imm(o4.up),
    .reg_zero(o4.rz), .halt(o4.halt),
    .bus_err(o4.berr), .illegal(o4.ill),
    .state(o4.st));

  multicycle_control_fsm #(.WAIT_MAX(0)) dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .instr_op(instr_op), .instr_func(instr_func),
    .equal(equal),
    .imemREN(o0.imem), .dmemREN(o0.dren),
    .dmemWEN(o0.dwen), .ir_wen(o0.irw),
    .pc_wen(o0.pcw), .pc_src(o0.pcs),
    .reg_wen(o0.rw), .reg_dst(o0.rd), .wsel(o0.ws),
    .alu_op(o0.aop), .alu_src(o0.asrc),
    .ext_op(o0.ext), .upper_imm(o0.up),
    .reg_zero(o0.rz), .halt(o0.halt),
    .bus_err(o0.berr), .illegal(o0.ill),
    .state(o0.st));

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // f = {alu_src, ext_op, upper_imm, reg_zero}
  function automatic void add(input logic [5:0] op, fn,
                              input kind_t k,
                              input logic [3:0] aop, f);
    vec_t r;
    r.op = op; r.fn = fn; r.k = k; r.aop = aop; r.f = f;
    tab.push_back(r);
  endfunction

  function automatic vec_t find(input logic [5:0] op, fn);
    foreach (tab[i])
      if (tab[i].op == op && tab[i].fn == fn) return tab[i];
    return tab[0];
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t r;
    r = '0; r.st = st; r.ext = 1'b1;
    return r;
  endfunction

  function automatic obs_t alu(input vec_t x, input logic [2:0] st);
    obs_t r;
    r = '0; r.st = st; r.aop = x.aop;
    {r.asrc, r.ext, r.up, r.rz} = x.f;
    return r;
  endfunction

  task automatic check(input obs_t got, want, input string tag);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic ih, dh, input obs_t x,
                     input string tag);
    ihit = ih; dhit = dh;
    @(negedge CLK);
    check(o4, x, tag);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(rb(), rb(), obs_t'(0), "reset");
    RST = 1'b0;
  endtask

  // One instruction from FETCH back to FETCH, with fw ihit and
  // mw dhit wait cycles; hits outside FETCH/MEM are random noise.
  task automatic run(input vec_t x, input logic eq,
                     input int fw, mw, input string tag);
    obs_t r;
    instr_op = x.op; instr_func = x.fn; equal = eq;
    for (int i = 0; i < fw; i++) begin
      r = base(3'd0); r.imem = 1'b1;
      cyc(1'b0, rb(), r, {tag, " fetch-wait"});
    end
    r = base(3'd0); r.imem = 1'b1; r.irw = 1'b1;
    cyc(1'b1, rb(), r, {tag, " fetch"});
    r = base(3'd1); r.ill = (x.k == K_BAD);
    cyc(rb(), rb(), r, {tag, " decode"});
    if (x.k == K_HALT) begin
      for (int i = 0; i < 3; i++) begin
        r = base(3'd5); r.halt = 1'b1;
        cyc(rb(), rb(), r, {tag, " halted"});
      end
      do_reset();
      return;
    end
    r = alu(x, 3'd2);
    case (x.k)
      K_BEQ: begin r.pcw = 1; r.pcs = eq ? 2'd1 : 2'd0; end
      K_BNE: begin r.pcw = 1; r.pcs = eq ? 2'd0 : 2'd1; end
      K_J:   begin r.pcw = 1; r.pcs = 2'd2; end
      K_JAL: begin
        r.pcw = 1; r.pcs = 2'd2;
        r.rw = 1; r.rd = 2'd2; r.ws = 2'd2;
      end
      K_JR:  begin r.pcw = 1; r.pcs = 2'd3; end
      K_BAD: r.pcw = 1;
      default: ;
    endcase
    cyc(rb(), rb(), r, {tag, " exec"});
    if (x.k == K_LW || x.k == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        r = alu(x, 3'd3);
        r.dren = (x.k == K_LW);
        r.dwen = (x.k == K_SW);
        r.pcw = (i == mw) && (x.k == K_SW);
        cyc(rb(), i == mw, r, {tag, " mem"});
      end
    end
    if (x.k inside {K_R, K_I, K_LW}) begin
      r = alu(x, 3'd4); r.rw = 1; r.pcw = 1;
      r.rd = (x.k == K_R) ? 2'd1 : 2'd0;
      r.ws = (x.k == K_LW) ? 2'd1 : 2'd0;
      cyc(rb(), rb(), r, {tag, " wb"});
    end
  endtask

  initial begin
    add(RTYPE, ADDU, K_R, ALU_ADD, 4'b0100);
    add(RTYPE, SUBU, K_R, ALU_SUB, 4'b0100);
    add(RTYPE, AND, K_R, ALU_AND, 4'b0100);
    add(RTYPE, OR, K_R, ALU_OR, 4'b0100);
    add(RTYPE, XOR, K_R, ALU_XOR, 4'b0100);
    add(RTYPE, NOR, K_R, ALU_NOR, 4'b0100);
    add(RTYPE, SLT, K_R, ALU_SLT, 4'b0100);
    add(RTYPE, SLTU, K_R, ALU_SLTU, 4'b0100);
    add(RTYPE, SLL, K_R, ALU_SLL, 4'b0100);
    add(RTYPE, SRL, K_R, ALU_SRL, 4'b0100);
    add(RTYPE, JR, K_JR, ALU_SLL, 4'b0100);
    add(RTYPE, 6'h3f, K_BAD, ALU_SLL, 4'b0100);
    add(ADDIU, 6'd0, K_I, ALU_ADD, 4'b1100);
    add(SLTI, 6'd0, K_I, ALU_SLT, 4'b1100);
    add(SLTIU, 6'd0, K_I, ALU_SLTU, 4'b1100);
    add(ANDI, 6'd0, K_I, ALU_AND, 4'b1000);
    add(ORI, 6'd0, K_I, ALU_OR, 4'b1000);
    add(XORI, 6'd0, K_I, ALU_XOR, 4'b1000);
    add(LUI, 6'd0, K_I, ALU_OR, 4'b1011);
    add(LW, 6'd0, K_LW, ALU_ADD, 4'b1100);
    add(SW, 6'd0, K_SW, ALU_ADD, 4'b1100);
    add(BEQ, 6'd0, K_BEQ, ALU_SUB, 4'b0100);
    add(BNE, 6'd0, K_BNE, ALU_SUB, 4'b0100);
    add(J, 6'd0, K_J, ALU_SLL, 4'b0100);
    add(JAL, 6'd0, K_JAL, ALU_SLL, 4'b0100);
    add(6'h01, 6'd0, K_BAD, ALU_SLL, 4'b0100);
    add(HALT, 6'd0, K_HALT, ALU_SLL, 4'b0100);

    @(posedge CLK); #1;
    do_reset();

    foreach (tab[i])
      run(tab[i], 1'b1, 0, 0, $sformatf("tab%0d", i));

    run(find(BEQ, 6'd0), 1'b0, 0, 0, "beq-nt");
    run(find(BNE, 6'd0), 1'b0, 1, 0, "bne-t");
    run(find(LW, 6'd0), 1'b0, 0, 3, "lw-dhit3");
    run(find(SW, 6'd0), 1'b0, 2, 3, "sw-dhit3");
    run(find(RTYPE, ADDU), 1'b0, 3, 0, "ihit-4th");

    for (int i = 0; i < 4; i++) begin
      e = base(3'd0); e.imem = 1'b1;
      cyc(1'b0, rb(), e, "fetch-timeout");
    end
    for (int i = 0; i < 3; i++) begin
      e = base(3'd6); e.berr = 1'b1;
      cyc(rb(), rb(), e, "fetch-error");
    end
    do_reset();

    v = find(LW, 6'd0);
    instr_op = v.op; instr_func = v.fn;
    e = base(3'd0); e.imem = 1'b1; e.irw = 1'b1;
    cyc(1'b1, 1'b0, e, "mto fetch");
    cyc(1'b0, 1'b0, base(3'd1), "mto decode");
    cyc(1'b0, 1'b0, alu(v, 3'd2), "mto exec");
    for (int i = 0; i < 4; i++) begin
      e = alu(v, 3'd3); e.dren = 1'b1;
      cyc(1'b1, 1'b0, e, "mto mem");
    end
    e = base(3'd6); e.berr = 1'b1;
    cyc(1'b1, 1'b1, e, "mto error");
    do_reset();

    v = find(SW, 6'd0);
    instr_op = v.op; instr_func = v.fn;
    e = base(3'd0); e.imem = 1'b1; e.irw = 1'b1;
    cyc(1'b1, 1'b0, e, "swrst fetch");
    cyc(1'b0, 1'b0, base(3'd1), "swrst decode");
    cyc(1'b0, 1'b0, alu(v, 3'd2), "swrst exec");
    e = alu(v, 3'd3); e.dwen = 1'b1;
    cyc(1'b0, 1'b0, e, "swrst mem");
    RST = 1'b1;
    cyc(1'b0, 1'b1, obs_t'(0), "swrst in-reset");
    RST = 1'b0;
    e = base(3'd0); e.imem = 1'b1;
    cyc(1'b0, 1'b1, e, "swrst after");
    do_reset();

    instr_op = ADDIU; instr_func = 6'd0;
    for (int i = 0; i < 100; i++) begin
      ihit = 1'b0; dhit = rb();
      @(negedge CLK);
      e = base(3'd0); e.imem = 1'b1;
      check(o0, e, "nowait fetch");
      @(posedge CLK); #1;
    end
    ihit = 1'b1;
    @(negedge CLK);
    e = base(3'd6); e.berr = 1'b1;
    check(o4, e, "wait4 errored");
    e = base(3'd0); e.imem = 1'b1; e.irw = 1'b1;
    check(o0, e, "nowait hit");
    @(posedge CLK); #1;
    ihit = 1'b0;
    @(negedge CLK);
    check(o0, base(3'd1), "nowait decode");
    @(posedge CLK); #1;
    do_reset();

    for (int n = 0; n < 300; n++) begin
      v = tab[$urandom_range(0, tab.size() - 1)];
      if (v.k == K_HALT) continue;
      if (v.op != RTYPE) v.fn = 6'($urandom);
      run(v, rb(), $urandom_range(0, 3),
          $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end
    e = base(3'd0); e.imem = 1'b1;
    cyc(1'b0, 1'b0, e, "final fetch");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
